// File: rtl/sprite_blit_writer.sv
// Streams a row-major sprite into the frame-buffer write port at (dst_x, dst_y),
// clipping off-screen pixels and skipping the transparent colour key.
module sprite_blit_writer #(
  parameter int                    DATA_WIDTH  = 12,
  parameter int                    ADDR_WIDTH  = 20,
  parameter int                    FB_WIDTH    = 320,
  parameter int                    FB_HEIGHT   = 240,
  parameter int                    DIM_WIDTH   = 10,
  parameter logic [DATA_WIDTH-1:0] TRANSPARENT = 12'h0F0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  dst_x,
  input  logic [DIM_WIDTH-1:0]  dst_y,
  input  logic [DIM_WIDTH-1:0]  spr_w,
  input  logic [DIM_WIDTH-1:0]  spr_h,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [DIM_WIDTH-1:0]  ONE_D  = DIM_WIDTH'(1);
  localparam logic [DIM_WIDTH:0]    FB_W_C = (DIM_WIDTH+1)'(FB_WIDTH);
  localparam logic [DIM_WIDTH:0]    FB_H_C = (DIM_WIDTH+1)'(FB_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(FB_WIDTH);

  state_t               state;
  logic [DIM_WIDTH-1:0] x0, y0, w_m1, h_m1;
  logic [DIM_WIDTH-1:0] col, row;

  logic                  xfer;
  logic [DIM_WIDTH:0]    px, py;
  logic                  visible, opaque, last_col, last_pix;
  logic [ADDR_WIDTH-1:0] addr_calc;

  // One extra bit on the pixel coordinates so sprites hanging past the
  // right/bottom edge never wrap back onto the screen.
  always_comb begin
    xfer      = pix_valid && pix_ready;
    px        = {1'b0, x0} + {1'b0, col};
    py        = {1'b0, y0} + {1'b0, row};
    visible   = (px < FB_W_C) && (py < FB_H_C);
    opaque    = (pix_data != TRANSPARENT);
    last_col  = (col == w_m1);
    last_pix  = last_col && (row == h_m1);
    addr_calc = ADDR_WIDTH'(py) * STRIDE + ADDR_WIDTH'(px);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pix_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      x0        <= '0;
      y0        <= '0;
      w_m1      <= '0;
      h_m1      <= '0;
      col       <= '0;
      row       <= '0;
    end else begin
      done <= 1'b0;
      we   <= 1'b0;
      case (state)
        IDLE: begin
          // The cycle done is high is the tail of the previous blit: drop busy
          // and refuse any start request that coincides with it.
          if (done) begin
            busy <= 1'b0;
          end else if (start) begin
            x0   <= dst_x;
            y0   <= dst_y;
            w_m1 <= spr_w - ONE_D;
            h_m1 <= spr_h - ONE_D;
            col  <= '0;
            row  <= '0;
            busy <= 1'b1;
            if (spr_w == '0 || spr_h == '0) begin
              state <= FIN;
            end else begin
              state     <= RUN;
              pix_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            if (visible && opaque) begin
              we    <= 1'b1;
              waddr <= addr_calc;
              wdata <= pix_data;
            end
            if (last_col) begin
              col <= '0;
              row <= row + ONE_D;
            end else begin
              col <= col + ONE_D;
            end
            if (last_pix) begin
              state     <= FIN;
              pix_ready <= 1'b0;
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blit_writer.sv
// Directed bench for sprite_blit_writer: a reference model pushes expected
// frame-buffer writes into a queue, a negedge monitor pops and compares them.
module tb_sprite_blit_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [9:0]  dst_x, dst_y, spr_w, spr_h;
  logic        pix_valid;
  logic [11:0] pix_data;
  logic        pix_ready, busy, done, we;
  logic [19:0] waddr;
  logic [11:0] wdata;

  sprite_blit_writer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .dst_x     (dst_x),
    .dst_y     (dst_y),
    .spr_w     (spr_w),
    .spr_h     (spr_h),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .busy      (busy),
    .done      (done),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          write_cnt = 0;
  logic [31:0] exp_q[$];
  int          m_x, m_y, m_w, m_col, m_row;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write the DUT issues must match the oldest expectation.
  always @(negedge clk) begin
    logic [31:0] e;
    if (we) begin
      write_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("write", {waddr, wdata}, e);
      end
    end
  end

  task automatic start_blit(input int x, input int y, input int w, input int h);
    start = 1'b1;
    dst_x = 10'(x); dst_y = 10'(y); spr_w = 10'(w); spr_h = 10'(h);
    @(negedge clk);
    start = 1'b0;
    m_x = x; m_y = y; m_w = w; m_col = 0; m_row = 0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic send_pix(input logic [11:0] d);
    int n = 0;
    int x, y;
    pix_valid = 1'b1;
    pix_data  = d;
    while (!pix_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!pix_ready) begin
      check("pix_ready_timeout", 32'(pix_ready), 32'd1);
    end else begin
      x = m_x + m_col;
      y = m_y + m_row;
      if (x < 320 && y < 240 && d != 12'h0F0)
        exp_q.push_back({20'(y * 320 + x), d});
      if (m_col == m_w - 1) begin
        m_col = 0;
        m_row++;
      end else begin
        m_col++;
      end
    end
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  // Called at the negedge just after the final transfer; optionally fires a
  // start on the done cycle, which must be ignored.
  task automatic finish_blit(input bit poke_start);
    check("ready_drop", 32'(pix_ready), 32'd0);
    check("no_done_yet", 32'(done), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd1);
    if (poke_start) begin
      start = 1'b1; dst_x = 10'd0; dst_y = 10'd0; spr_w = 10'd1; spr_h = 10'd1;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_single", 32'(done), 32'd0);
    check("busy_clear", 32'(busy), 32'd0);
    if (poke_start) begin
      @(negedge clk);
      check("start_on_done_ignored", {30'd0, busy, pix_ready}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    dst_x = '0; dst_y = '0; spr_w = '0; spr_h = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {28'd0, pix_ready, busy, done, we}, 32'd0);
    check("reset_waddr", 32'(waddr), 32'd0);
    check("reset_wdata", 32'(wdata), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: 2x2 at the origin, back-to-back
    start_blit(0, 0, 2, 2);
    send_pix(12'h111); send_pix(12'h222); send_pix(12'h333); send_pix(12'h444);
    finish_blit(1'b0);
    check("t1_writes", 32'(write_cnt), 32'd4);

    // 2: bottom-right corner, three pixels clipped
    start_blit(319, 239, 2, 2);
    send_pix(12'hAAA); send_pix(12'hBBB); send_pix(12'hCCC); send_pix(12'hDDD);
    finish_blit(1'b0);
    check("t2_writes", 32'(write_cnt), 32'd5);

    // 3: transparent middle pixel, plus start on the done cycle
    start_blit(5, 7, 3, 1);
    send_pix(12'h123); send_pix(12'h0F0); send_pix(12'h456);
    finish_blit(1'b1);
    check("t3_writes", 32'(write_cnt), 32'd7);

    // 4: zero-width sprite consumes nothing
    pix_valid = 1'b1; pix_data = 12'h555;
    start_blit(3, 3, 0, 5);
    check("t4_no_ready", 32'(pix_ready), 32'd0);
    finish_blit(1'b0);
    pix_valid = 1'b0;
    check("t4_writes", 32'(write_cnt), 32'd7);

    // 5: 4x4 at (10,20) with random gaps and an ignored mid-blit start
    start_blit(10, 20, 4, 4);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (i == 6) begin
        start = 1'b1; dst_x = 10'd0; dst_y = 10'd0; spr_w = 10'd1; spr_h = 10'd1;
        @(negedge clk);
        start = 1'b0;
        check("t5_start_ignored", 32'(pix_ready), 32'd1);
      end
      send_pix(12'h200 + 12'(i));
    end
    finish_blit(1'b0);
    check("t5_writes", 32'(write_cnt), 32'd23);

    // 6: asynchronous reset mid-blit, then a fresh 1x1 blit
    start_blit(0, 0, 4, 4);
    for (int i = 0; i < 5; i++) send_pix(12'h300 + 12'(i));
    #2 reset_n = 1'b0;
    #1;
    check("t6_reset_ctrl", {28'd0, pix_ready, busy, done, we}, 32'd0);
    check("t6_reset_waddr", 32'(waddr), 32'd0);
    check("t6_reset_wdata", 32'(wdata), 32'd0);
    check("t6_queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_blit(1, 1, 1, 1);
    send_pix(12'h7AB);
    finish_blit(1'b0);
    check("t6_writes", 32'(write_cnt), 32'd29);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
